apb_timer: RTL and testbench



---
 rtl/apb_timer_pkg.sv | 27 ++
 rtl/apb_timer_prescaler.sv | 46 ++++
 rtl/apb_timer.sv | 165 ++++++++++++++++
 tb/tb_apb_timer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg -- shared constants for the APB down-counting timer.
//   DATA_W           : APB data width.
//   OFF_*            : byte offsets of the four registers (decoded on [7:2]).
//   CTRL_* / STATUS_*: bit positions of the CTRL and STATUS fields.
//   reg_idx()        : word index of a byte address.
package apb_timer_pkg;

  localparam int DATA_W = 32;

  localparam logic [7:0] OFF_LOAD   = 8'h00;
  localparam logic [7:0] OFF_VALUE  = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;

  localparam int CTRL_EN_BIT        = 0;
  localparam int CTRL_PERIODIC_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT    = 2;
  localparam int CTRL_PRESCALE_LSB  = 8;
  localparam int CTRL_PRESCALE_MSB  = 15;
  localparam int STATUS_EXPIRED_BIT = 0;

  // Word index of a byte offset; the low two address bits are not decoded.
  function automatic logic [5:0] reg_idx(input logic [7:0] addr);
    return addr[7:2];
  endfunction

endpackage

// File: rtl/apb_timer_prescaler.sv
// apb_timer_prescaler -- 8-bit prescaler producing a one-cycle tick.
//   clk_i      : clock (rising edge).
//   rst_ni     : asynchronous active-low reset.
//   enable_i   : count enable; when low the counter is held at 0.
//   clear_i    : synchronous clear of the counter.
//   prescale_i : terminal count; the counter runs 0..prescale_i.
//   tick_o     : high for the cycle in which the counter sits at terminal.
module apb_timer_prescaler (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       clear_i,
  input  logic [7:0] prescale_i,
  output logic       tick_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       terminal_s;

  // ">=" lets a prescale lowered below the running count wrap immediately.
  assign terminal_s = (cnt_q >= prescale_i);
  assign tick_o     = enable_i & terminal_s;

  // Next count: held at 0 when disabled or cleared, wraps at terminal.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i || clear_i) begin
      cnt_d = 8'd0;
    end else if (terminal_s) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_timer.sv
// apb_timer -- APB slave down-counting timer with prescaler and level IRQ.
//   PCLK, PRESETN          : clock and asynchronous active-low reset.
//   PSEL/PENABLE/PWRITE    : APB control; writes commit in the access phase.
//   PADDR[7:0], PWDATA[31:0]: address (decoded on [7:2]) and write data.
//   PRDATA[31:0]           : combinational read data, 0 when not reading.
//   PREADY                 : always 1 (no wait states).
//   PSLVERR                : error response for unmapped offsets / VALUE writes
//                            when APB_TIMER_PSLVERR_EN is defined, else 0.
//   TIMER_IRQ              : registered EXPIRED & IRQ_EN.
// Registers: 0x00 LOAD, 0x04 VALUE (RO), 0x08 CTRL, 0x0C STATUS (W1C).
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter logic [31:0] RESET_LOAD = 32'hFFFF_FFFF
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              TIMER_IRQ
);

  logic [DATA_W-1:0] load_q, load_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic              en_q, en_d;
  logic              periodic_q, periodic_d;
  logic              irq_en_q, irq_en_d;
  logic [7:0]        prescale_q, prescale_d;
  logic              expired_q, expired_d;
  logic              irq_q;

  logic [5:0]        idx_s;
  logic              access_wr_s;
  logic              wr_load_s, wr_ctrl_s, wr_status_s;
  logic              tick_s, expire_s, dec_s;
  logic [DATA_W-1:0] ctrl_rd_s;
  logic              unused_s;

  assign unused_s    = ^PADDR[1:0];
  assign idx_s       = reg_idx(PADDR);
  assign access_wr_s = PSEL & PENABLE & PWRITE;
  assign wr_load_s   = access_wr_s & (idx_s == reg_idx(OFF_LOAD));
  assign wr_ctrl_s   = access_wr_s & (idx_s == reg_idx(OFF_CTRL));
  assign wr_status_s = access_wr_s & (idx_s == reg_idx(OFF_STATUS));

  apb_timer_prescaler u_prescaler (
    .clk_i      (PCLK),
    .rst_ni     (PRESETN),
    .enable_i   (en_q),
    .clear_i    (wr_load_s),
    .prescale_i (prescale_q),
    .tick_o     (tick_s)
  );

  // A LOAD write overrides whatever the tick would have done this cycle.
  assign expire_s = tick_s & ~wr_load_s & (value_q == 32'd0);
  assign dec_s    = tick_s & ~wr_load_s & (value_q != 32'd0);

  assign ctrl_rd_s = {16'd0, prescale_q, 5'd0, irq_en_q, periodic_q, en_q};

  // Next-state for the timer registers.
  always_comb begin
    load_d     = load_q;
    value_d    = value_q;
    en_d       = en_q;
    periodic_d = periodic_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
    expired_d  = expired_q;

    if (wr_load_s) begin
      load_d  = PWDATA;
      value_d = PWDATA;
    end else if (expire_s) begin
      value_d = periodic_q ? load_q : 32'd0;
    end else if (dec_s) begin
      value_d = value_q - 32'd1;
    end else begin
      value_d = value_q;
    end

    if (wr_ctrl_s) begin
      en_d       = PWDATA[CTRL_EN_BIT];
      periodic_d = PWDATA[CTRL_PERIODIC_BIT];
      irq_en_d   = PWDATA[CTRL_IRQ_EN_BIT];
      prescale_d = PWDATA[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB];
    end else begin
      en_d       = en_q;
    end

    // One-shot expiry disables the timer even against a simultaneous CTRL write.
    if (expire_s && !periodic_q) begin
      en_d = 1'b0;
    end else begin
      en_d = en_d;
    end

    // Set has priority over a simultaneous write-1-to-clear.
    if (expire_s) begin
      expired_d = 1'b1;
    end else if (wr_status_s && PWDATA[STATUS_EXPIRED_BIT]) begin
      expired_d = 1'b0;
    end else begin
      expired_d = expired_q;
    end
  end

  // Timer register bank and registered interrupt.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      load_q     <= RESET_LOAD;
      value_q    <= RESET_LOAD;
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      prescale_q <= 8'd0;
      expired_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      load_q     <= load_d;
      value_q    <= value_d;
      en_q       <= en_d;
      periodic_q <= periodic_d;
      irq_en_q   <= irq_en_d;
      prescale_q <= prescale_d;
      expired_q  <= expired_d;
      irq_q      <= expired_q & irq_en_q;
    end
  end

  // Read mux; forced to 0 outside a read and while reset is held.
  always_comb begin
    PRDATA = 32'd0;
    if (PRESETN && PSEL && !PWRITE) begin
      case (idx_s)
        reg_idx(OFF_LOAD):   PRDATA = load_q;
        reg_idx(OFF_VALUE):  PRDATA = value_q;
        reg_idx(OFF_CTRL):   PRDATA = ctrl_rd_s;
        reg_idx(OFF_STATUS): PRDATA = {31'd0, expired_q};
        default:             PRDATA = 32'd0;
      endcase
    end else begin
      PRDATA = 32'd0;
    end
  end

`ifdef APB_TIMER_PSLVERR_EN
  logic bad_access_s;
  assign bad_access_s = (idx_s > reg_idx(OFF_STATUS)) |
                        (PWRITE & (idx_s == reg_idx(OFF_VALUE)));
  assign PSLVERR = PRESETN & PSEL & PENABLE & bad_access_s;
`else
  assign PSLVERR = 1'b0;
`endif

  assign PREADY    = 1'b1;
  assign TIMER_IRQ = irq_q;

endmodule

// File: tb/tb_apb_timer.sv
// tb_apb_timer -- directed bench for apb_timer with a behavioural model
// compared every falling edge, plus literal expectations for key scenarios.
module tb_apb_timer;

  logic        PCLK = 1'b0;
  logic        PRESETN;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, TIMER_IRQ;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  apb_timer #(.RESET_LOAD(32'hFFFF_FFFF)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .TIMER_IRQ(TIMER_IRQ)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_load = 32'hFFFF_FFFF, m_value = 32'hFFFF_FFFF;
  logic        m_en = 1'b0, m_periodic = 1'b0, m_irqen = 1'b0;
  logic        m_expired = 1'b0, m_irq = 1'b0;
  logic [7:0]  m_prescale = 8'd0;
  int          m_since = 0;   // cycles elapsed since the prescaler last restarted

  logic       m_wr, m_ldwr, m_tick, m_zero_tick;
  logic [5:0] m_idx;
  assign m_wr        = PSEL && PENABLE && PWRITE;
  assign m_idx       = PADDR[7:2];
  assign m_ldwr      = m_wr && (m_idx == 6'd0);
  assign m_tick      = m_en && (m_since >= int'(m_prescale)) && !m_ldwr;
  assign m_zero_tick = m_tick && (m_value == 32'd0);

  always @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      m_load <= 32'hFFFF_FFFF; m_value <= 32'hFFFF_FFFF;
      m_en <= 1'b0; m_periodic <= 1'b0; m_irqen <= 1'b0; m_prescale <= 8'd0;
      m_expired <= 1'b0; m_irq <= 1'b0; m_since <= 0;
    end else begin
      m_irq   <= m_expired && m_irqen;
      m_since <= (!m_en || m_ldwr || m_tick) ? 0 : m_since + 1;
      if (m_ldwr) begin
        m_load <= PWDATA; m_value <= PWDATA;
      end else if (m_tick) begin
        m_value <= (m_value == 32'd0) ? (m_periodic ? m_load : 32'd0) : m_value - 32'd1;
      end
      if (m_wr && m_idx == 6'd2) begin
        m_en <= PWDATA[0] && !(m_zero_tick && !m_periodic);
        m_periodic <= PWDATA[1]; m_irqen <= PWDATA[2]; m_prescale <= PWDATA[15:8];
      end else if (m_zero_tick && !m_periodic) begin
        m_en <= 1'b0;
      end
      if (m_zero_tick) m_expired <= 1'b1;
      else if (m_wr && m_idx == 6'd3 && PWDATA[0]) m_expired <= 1'b0;
    end
  end

  function automatic logic [31:0] model_rd(input logic [7:0] a);
    case (a[7:2])
      6'd0:    return m_load;
      6'd1:    return m_value;
      6'd2:    return {16'd0, m_prescale, 5'd0, m_irqen, m_periodic, m_en};
      6'd3:    return {31'd0, m_expired};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_err();
`ifdef APB_TIMER_PSLVERR_EN
    return PRESETN && PSEL && PENABLE && ((PADDR[7:2] > 6'd3) || (PWRITE && PADDR[7:2] == 6'd1));
`else
    return 1'b0;
`endif
  endfunction

  // Compare DUT outputs against the model every falling edge.
  always @(negedge PCLK) begin
    check("model_irq", {31'd0, TIMER_IRQ}, {31'd0, m_irq});
    check("model_pready", {31'd0, PREADY}, 32'd1);
    check("model_pslverr", {31'd0, PSLVERR}, {31'd0, model_err()});
    check("model_prdata", PRDATA,
          (PRESETN && PSEL && !PWRITE) ? model_rd(PADDR) : 32'd0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge PCLK); #1;
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(negedge PCLK); err = PSLVERR;
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(negedge PCLK); d = PRDATA;
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Setup-phase-only read: PRDATA is combinational, so no transfer is needed.
  task automatic peek(input logic [7:0] a, output logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    #1 d = PRDATA;
  endtask

  logic [31:0] rd;
  logic        err;
  logic [31:0] seq_exp [5] = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3};
  logic        exp_err;
  logic [7:0]  reg_addr [4] = '{8'h00, 8'h04, 8'h08, 8'h0C};

  initial begin
`ifdef APB_TIMER_PSLVERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    PRESETN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 8'h00; PWDATA = 32'd0;
    repeat (3) @(posedge PCLK);
    #1 check("reset_irq", {31'd0, TIMER_IRQ}, 32'd0);
    PRESETN = 1'b1;

    // Reset values of all four registers.
    apb_read(8'h00, rd); check("rst_load", rd, 32'hFFFF_FFFF);
    apb_read(8'h04, rd); check("rst_value", rd, 32'hFFFF_FFFF);
    apb_read(8'h08, rd); check("rst_ctrl", rd, 32'h0);
    apb_read(8'h0C, rd); check("rst_status", rd, 32'h0);

    // Periodic, prescale 0, IRQ enabled.
    apb_write(8'h00, 32'd3, err);
    apb_write(8'h08, 32'h0000_0007, err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h04;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK); check("periodic_value", PRDATA, seq_exp[i]);
    end
    check("periodic_irq_late", {31'd0, TIMER_IRQ}, 32'd0);
    PADDR = 8'h0C; #1 check("periodic_expired", PRDATA, 32'd1);
    @(negedge PCLK); check("periodic_irq", {31'd0, TIMER_IRQ}, 32'd1);
    #1;
    apb_write(8'h08, 32'h0, err);
    apb_write(8'h0C, 32'h1, err);

    // W1C colliding with expiry, then a clean W1C.
    apb_write(8'h00, 32'd3, err);
    apb_write(8'h08, 32'h0000_0007, err);
    wait_cycles(2);
    apb_write(8'h0C, 32'h1, err);
    peek(8'h0C, rd); check("w1c_vs_set", rd, 32'd1);
    apb_write(8'h0C, 32'h1, err);
    peek(8'h0C, rd); check("w1c_clear", rd, 32'd0);
    check("w1c_irq_hold", {31'd0, TIMER_IRQ}, 32'd1);
    wait_cycles(1);
    check("w1c_irq_drop", {31'd0, TIMER_IRQ}, 32'd0);
    apb_write(8'h08, 32'h0, err);
    apb_write(8'h0C, 32'h1, err);

    // One-shot with prescale 2.
    apb_write(8'h00, 32'd2, err);
    apb_write(8'h08, 32'h0000_0201, err);
    wait_cycles(3);
    peek(8'h04, rd); check("oneshot_v1", rd, 32'd1);
    wait_cycles(5);
    peek(8'h08, rd); check("oneshot_en_before", rd, 32'h0000_0201);
    peek(8'h04, rd); check("oneshot_v0", rd, 32'd0);
    wait_cycles(1);
    peek(8'h08, rd); check("oneshot_en_off", rd, 32'h0000_0200);
    peek(8'h04, rd); check("oneshot_value", rd, 32'd0);
    peek(8'h0C, rd); check("oneshot_expired", rd, 32'd1);
    wait_cycles(1);
    check("oneshot_irq", {31'd0, TIMER_IRQ}, 32'd0);

    // Unmapped write and VALUE write.
    apb_write(8'h10, 32'hDEAD_BEEF, err); check("err_unmapped", {31'd0, err}, {31'd0, exp_err});
    apb_write(8'h04, 32'h1234_5678, err); check("err_value_wr", {31'd0, err}, {31'd0, exp_err});
    apb_read(8'h00, rd); check("keep_load", rd, 32'd2);
    apb_read(8'h04, rd); check("keep_value", rd, 32'd0);
    apb_read(8'h08, rd); check("keep_ctrl", rd, 32'h0000_0200);
    apb_read(8'h0C, rd); check("keep_status", rd, 32'd1);
    apb_read(8'h10, rd); check("unmapped_rd", rd, 32'd0);

    // Reset mid-count with IRQ asserted.
    apb_write(8'h00, 32'd8, err);
    apb_write(8'h08, 32'h0000_0005, err);
    wait_cycles(3);
    peek(8'h04, rd); check("midcount_value", rd, 32'd5);
    check("midcount_irq", {31'd0, TIMER_IRQ}, 32'd1);
    #1 PRESETN = 1'b0;
    #1;
    check("rst_async_prdata", PRDATA, 32'd0);
    check("rst_async_pslverr", {31'd0, PSLVERR}, 32'd0);
    check("rst_async_irq", {31'd0, TIMER_IRQ}, 32'd0);
    wait_cycles(2);
    PRESETN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apb_read(reg_addr[i], rd);
      check("post_rst_reg", rd, (i < 2) ? 32'hFFFF_FFFF : 32'd0);
    end
    wait_cycles(3);
    check("post_rst_irq", {31'd0, TIMER_IRQ}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
